// File: rtl/dif_mc_if.sv
// Sample-in / difference-out bundle for dif_mc: tagged ADC samples one way,
// registered differences, priming flags and channel error the other.
`timescale 1ns/1ps
interface dif_mc_if #(
    parameter int DW = 12,
    parameter int CW = 2
);
    logic                 in_valid;
    logic [CW-1:0]        in_ch;
    logic [DW-1:0]        in_data;
    logic                 out_valid;
    logic [CW-1:0]        out_ch;
    logic signed [DW+2:0] d1;
    logic signed [DW+2:0] d2;
    logic signed [DW+2:0] d3;
    logic [2:0]           prime;
    logic                 ch_err;

    modport master (
        output in_valid, in_ch, in_data,
        input  out_valid, out_ch, d1, d2, d3, prime, ch_err
    );

    modport slave (
        input  in_valid, in_ch, in_data,
        output out_valid, out_ch, d1, d2, d3, prime, ch_err
    );
endinterface

// File: rtl/dif_mc.sv
// Multi-channel 1st/2nd/3rd-order backward-difference engine, one-cycle latency.
// Optional output clamp to SAT_W signed bits is enabled by defining DIF_SAT_EN.
`timescale 1ns/1ps
module dif_mc #(
    parameter int DW    = 12,
    parameter int CH    = 4,
    parameter int CW    = 2,
    parameter int SAT_W = DW + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr,
    dif_mc_if.slave  bus
);
    localparam int XW = DW + 3;

`ifdef DIF_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    typedef logic signed [XW-1:0] sx_t;

    localparam sx_t SAT_MAX = sx_t'((1 <<< (SAT_W - 1)) - 1);
    localparam sx_t SAT_MIN = sx_t'(-(1 <<< (SAT_W - 1)));

    function automatic sx_t sat(input sx_t v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    function automatic sx_t ext(input logic [DW-1:0] u);
        return sx_t'({3'b000, u});
    endfunction

    logic [DW-1:0] r_h1 [CH];
    logic [DW-1:0] r_h2 [CH];
    logic [DW-1:0] r_h3 [CH];
    logic [1:0]    r_pc [CH];

    logic          w_hit;
    logic [DW-1:0] w_h1, w_h2, w_h3;
    logic [1:0]    w_pc;
    logic          w_acc_p0;
    sx_t           w_x_p0, w_e1_p0, w_e2_p0, w_e3_p0;
    sx_t           w_d1_p0, w_d2_p0, w_d3_p0;

    logic          r_vld_p1;
    logic          r_err_p1;
    logic [CW-1:0] r_ch_p1;
    sx_t           r_d1_p1, r_d2_p1, r_d3_p1;
    logic [2:0]    r_prime_p1;

    // ---- stage p0: channel lookup and full-width differences ----
    always_comb begin
        w_hit = 1'b0;
        w_h1  = '0;
        w_h2  = '0;
        w_h3  = '0;
        w_pc  = '0;
        for (int c = 0; c < CH; c++) begin
            if (bus.in_ch == CW'(c)) begin
                w_hit = 1'b1;
                w_h1  = r_h1[c];
                w_h2  = r_h2[c];
                w_h3  = r_h3[c];
                w_pc  = r_pc[c];
            end
        end
    end

    always_comb begin
        w_acc_p0 = bus.in_valid && w_hit && !clr;
        w_x_p0   = ext(bus.in_data);
        w_e1_p0  = ext(w_h1);
        w_e2_p0  = ext(w_h2);
        w_e3_p0  = ext(w_h3);
        w_d1_p0  = w_x_p0 - w_e1_p0;
        w_d2_p0  = w_x_p0 - (w_e1_p0 <<< 1) + w_e2_p0;
        w_d3_p0  = w_x_p0 - ((w_e1_p0 <<< 1) + w_e1_p0)
                          + ((w_e2_p0 <<< 1) + w_e2_p0) - w_e3_p0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                r_h1[c] <= '0;
                r_h2[c] <= '0;
                r_h3[c] <= '0;
                r_pc[c] <= '0;
            end
        end else if (clr) begin
            for (int c = 0; c < CH; c++) begin
                r_h1[c] <= '0;
                r_h2[c] <= '0;
                r_h3[c] <= '0;
                r_pc[c] <= '0;
            end
        end else if (bus.in_valid) begin
            for (int c = 0; c < CH; c++) begin
                if (bus.in_ch == CW'(c)) begin
                    r_h3[c] <= r_h2[c];
                    r_h2[c] <= r_h1[c];
                    r_h1[c] <= bus.in_data;
                    if (r_pc[c] != 2'd3) r_pc[c] <= r_pc[c] + 2'd1;
                end
            end
        end
    end

    // ---- stage p1: registered results, held until the next accepted sample ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1   <= 1'b0;
            r_err_p1   <= 1'b0;
            r_ch_p1    <= '0;
            r_d1_p1    <= '0;
            r_d2_p1    <= '0;
            r_d3_p1    <= '0;
            r_prime_p1 <= '0;
        end else begin
            r_vld_p1 <= w_acc_p0;
            r_err_p1 <= bus.in_valid && !w_hit;
            if (w_acc_p0) begin
                r_ch_p1    <= bus.in_ch;
                r_d1_p1    <= SAT_ON ? sat(w_d1_p0) : w_d1_p0;
                r_d2_p1    <= SAT_ON ? sat(w_d2_p0) : w_d2_p0;
                r_d3_p1    <= SAT_ON ? sat(w_d3_p0) : w_d3_p0;
                r_prime_p1 <= {w_pc == 2'd3, w_pc >= 2'd2, w_pc != 2'd0};
            end
        end
    end

    assign bus.out_valid = r_vld_p1;
    assign bus.ch_err    = r_err_p1;
    assign bus.out_ch    = r_ch_p1;
    assign bus.d1        = r_d1_p1;
    assign bus.d2        = r_d2_p1;
    assign bus.d3        = r_d3_p1;
    assign bus.prime     = r_prime_p1;
endmodule

// File: tb/tb_dif_mc.sv
// Directed table-driven bench for dif_mc (DW=12, CH=4, CW=3, SAT_W=13), plus an
// asynchronous mid-stream reset sequence.
`timescale 1ns/1ps
module tb_dif_mc;
    localparam int DW = 12;
    localparam int CH = 4;
    localparam int CW = 3;
    localparam int SW = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;

    dif_mc_if #(.DW(DW), .CW(CW)) bus ();

    dif_mc #(.DW(DW), .CH(CH), .CW(CW), .SAT_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit c;
        int ch;
        int data;
        bit ev;
        bit ee;
        int ech;
        int e1;
        int e2;
        int e3;
        int ep;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic int clampx(input int v);
`ifdef DIF_SAT_EN
        if (v > (1 << (SW - 1)) - 1) return (1 << (SW - 1)) - 1;
        if (v < -(1 << (SW - 1))) return -(1 << (SW - 1));
`endif
        return v;
    endfunction

    function automatic vec_t mk(input bit v, input bit c, input int ch, input int data,
                                input bit ev, input bit ee, input int ech,
                                input int e1, input int e2, input int e3, input int ep);
        vec_t r;
        r.v = v; r.c = c; r.ch = ch; r.data = data;
        r.ev = ev; r.ee = ee; r.ech = ech;
        r.e1 = e1; r.e2 = e2; r.e3 = e3; r.ep = ep;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit c, input int ch, input int data);
        @(negedge clk);
        bus.in_valid = v;
        clr          = c;
        bus.in_ch    = CW'(ch);
        bus.in_data  = DW'(data);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        clr          = 1'b0;
    endtask

    task automatic chk_all(input string tag, input vec_t t);
        chk({tag, ".out_valid"}, int'(bus.out_valid), int'(t.ev));
        chk({tag, ".ch_err"},    int'(bus.ch_err),    int'(t.ee));
        chk({tag, ".out_ch"},    int'(bus.out_ch),    t.ech);
        chk({tag, ".d1"},        int'(bus.d1),        clampx(t.e1));
        chk({tag, ".d2"},        int'(bus.d2),        clampx(t.e2));
        chk({tag, ".d3"},        int'(bus.d3),        clampx(t.e3));
        chk({tag, ".prime"},     int'(bus.prime),     t.ep);
    endtask

    initial begin
        vec_t z;
        bus.in_valid = 1'b0;
        bus.in_ch    = '0;
        bus.in_data  = '0;

        // ramp on ch0, then clr-with-sample, bad channel, clr only
        tbl.push_back(mk(1,0,0,  10, 1,0,0,   10,   10,   10, 3'b000));
        tbl.push_back(mk(1,0,0,  20, 1,0,0,   10,    0,  -10, 3'b001));
        tbl.push_back(mk(1,0,0,  40, 1,0,0,   20,   10,   10, 3'b011));
        tbl.push_back(mk(1,0,0,  80, 1,0,0,   40,   20,   10, 3'b111));
        tbl.push_back(mk(1,1,0,   7, 0,0,0,   40,   20,   10, 3'b111));
        tbl.push_back(mk(1,0,0,   7, 1,0,0,    7,    7,    7, 3'b000));
        tbl.push_back(mk(1,0,5, 999, 0,1,0,    7,    7,    7, 3'b000));
        tbl.push_back(mk(1,0,0,   9, 1,0,0,    2,   -5,  -12, 3'b001));
        tbl.push_back(mk(0,1,0,   0, 0,0,0,    2,   -5,  -12, 3'b001));
        // ch0/ch1 interleave
        tbl.push_back(mk(1,0,0,   0, 1,0,0,    0,    0,    0, 3'b000));
        tbl.push_back(mk(1,0,1,   5, 1,0,1,    5,    5,    5, 3'b000));
        tbl.push_back(mk(1,0,0,   0, 1,0,0,    0,    0,    0, 3'b001));
        tbl.push_back(mk(1,0,1,   5, 1,0,1,    0,   -5,  -10, 3'b001));
        tbl.push_back(mk(1,0,0,   0, 1,0,0,    0,    0,    0, 3'b011));
        tbl.push_back(mk(1,0,1,   5, 1,0,1,    0,    0,    5, 3'b011));
        tbl.push_back(mk(1,0,0,4095, 1,0,0, 4095, 4095, 4095, 3'b111));
        tbl.push_back(mk(1,0,1,   5, 1,0,1,    0,    0,    0, 3'b111));
        tbl.push_back(mk(1,0,0,   0, 1,0,0,-4095,-8190,-12285,3'b111));
        tbl.push_back(mk(1,0,1,   5, 1,0,1,    0,    0,    0, 3'b111));
        // ch2 full-scale swing, ch3 single sample
        tbl.push_back(mk(1,0,2,   0, 1,0,2,    0,    0,    0, 3'b000));
        tbl.push_back(mk(1,0,2,4095, 1,0,2, 4095, 4095, 4095, 3'b001));
        tbl.push_back(mk(1,0,2,   0, 1,0,2,-4095,-8190,-12285,3'b011));
        tbl.push_back(mk(1,0,2,4095, 1,0,2, 4095, 8190, 16380, 3'b111));
        tbl.push_back(mk(1,0,3,4095, 1,0,3, 4095, 4095, 4095, 3'b000));
        tbl.push_back(mk(0,0,0,   0, 0,0,3, 4095, 4095, 4095, 3'b000));

        #12;
        z = mk(0,0,0,0, 0,0,0, 0,0,0, 0);
        chk_all("reset", z);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].c, tbl[i].ch, tbl[i].data);
            chk_all($sformatf("vec%0d", i), tbl[i]);
        end

        // async reset between edges right after a live result
        drive(1, 0, 2, 100);
        chk("pre_rst.out_valid", int'(bus.out_valid), 1);
        chk("pre_rst.d1", int'(bus.d1), clampx(-3995));
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", z);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 3);
        chk_all("post_rst", mk(1,0,0,3, 1,0,0, 3,3,3, 3'b000));
        drive(0, 0, 0, 0);
        chk("post_rst.pulse", int'(bus.out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
